ssp_master: RTL and testbench

Serial initiator for the SSP UART's synchronous serial port: accepts one register command (address, write/read, 12-bit data) on a valid/ready port, shifts it out as a 16-bit SSP frame, and returns the 16 bits captured from the slave. It sits on the host side of the SSP link and drives the select, clock and data lines the SSP UART slave decodes. It is the primary stimulus driver for board-level and loop-back test benches.

---
 rtl/ssp_master_pkg.sv | 28 ++
 rtl/ssp_sck_gen.sv | 51 +++++
 rtl/ssp_master.sv | 157 +++++++++++++++
 tb/tb_ssp_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_master_pkg.sv
// Shared types and frame layout for the SSP initiator.
package ssp_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int FRAME_W = 16;
  localparam int RA_MSB  = 15;
  localparam int WNR_BIT = 12;
  localparam int DATA_W  = 12;
  localparam int STS_W   = 4;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [2:0]        ra,
                                                    input logic              wnr,
                                                    input logic [DATA_W-1:0] di);
    logic [FRAME_W-1:0] frame;
    frame                 = {FRAME_W{1'b0}};
    frame[RA_MSB -: 3]    = ra;
    frame[WNR_BIT]        = wnr;
    frame[DATA_W-1:0]     = di;
    return frame;
  endfunction

endpackage

// File: rtl/ssp_sck_gen.sv
// SCK generator: toggles every CLK_DIV enabled cycles, idles low when disabled,
// and flags the Clk edges that drive SCK up or down.
module ssp_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic sck_rise_o,
  output logic sck_fall_o
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       wrap_s;

  // Half-period counter and SCK next state.
  always_comb begin
    cnt_d  = cnt_q;
    sck_d  = sck_q;
    wrap_s = en_i && (cnt_q == HALF_LAST);
    if (!en_i) begin
      cnt_d = 8'd0;
      sck_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d = 8'd0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter and SCK registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o      = sck_q;
  assign sck_rise_o = wrap_s && !sck_q;
  assign sck_fall_o = wrap_s && sck_q;

endmodule

// File: rtl/ssp_master.sv
// SSP initiator: one 16-bit mode-0 frame per accepted command, response
// captured from MISO and presented with a one-cycle Rsp_Vld pulse.
module ssp_master
  import ssp_master_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cmd_Vld,
  output logic              Cmd_Rdy,
  input  logic [2:0]        Cmd_RA,
  input  logic              Cmd_WnR,
  input  logic [DATA_W-1:0] Cmd_DI,
  output logic              Rsp_Vld,
  output logic [STS_W-1:0]  Rsp_Sts,
  output logic [DATA_W-1:0] Rsp_DO,
  output logic              Busy,
  output logic              SSP_SSEL,
  output logic              SSP_SCK,
  output logic              SSP_MOSI,
  input  logic              SSP_MISO
);

  localparam logic [7:0] HOLD_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(FRAME_GAP - 1);
  localparam bit         GAP_EN    = (FRAME_GAP != 0);

  state_e              state_q, state_d;
  logic [3:0]          bit_q, bit_d;
  logic [7:0]          wait_q, wait_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [FRAME_W-1:0]  rx_q, rx_d;
  logic                ssel_q, ssel_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [STS_W-1:0]    sts_q, sts_d;
  logic [DATA_W-1:0]   do_q, do_d;
  logic                sck_en_s, sck_rise_s, sck_fall_s;

  assign sck_en_s = (state_q == SHIFT);

  ssp_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .en_i       (sck_en_s),
    .sck_o      (SSP_SCK),
    .sck_rise_o (sck_rise_s),
    .sck_fall_o (sck_fall_s)
  );

  // Frame sequencing, shift registers and response capture.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    wait_d    = wait_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ssel_d    = ssel_q;
    rsp_vld_d = 1'b0;
    sts_d     = sts_q;
    do_d      = do_q;
    case (state_q)
      IDLE: begin
        if (Cmd_Vld) begin
          state_d = SHIFT;
          tx_d    = pack_frame(Cmd_RA, Cmd_WnR, Cmd_DI);
          bit_d   = 4'd0;
          ssel_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sck_rise_s) begin
          rx_d = {rx_q[FRAME_W-2:0], SSP_MISO};
        end else begin
          rx_d = rx_q;
        end
        // MOSI advances on SCK falls; the 16th fall ends the data phase.
        if (sck_fall_s) begin
          tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
            wait_d  = 8'd0;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (wait_q == HOLD_LAST) begin
          ssel_d    = 1'b0;
          rsp_vld_d = 1'b1;
          sts_d     = rx_q[FRAME_W-1 -: STS_W];
          do_d      = rx_q[DATA_W-1:0];
          wait_d    = 8'd0;
          if (GAP_EN) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ssel_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      bit_q     <= 4'd0;
      wait_q    <= 8'd0;
      tx_q      <= {FRAME_W{1'b0}};
      rx_q      <= {FRAME_W{1'b0}};
      ssel_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      sts_q     <= {STS_W{1'b0}};
      do_q      <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ssel_q    <= ssel_d;
      rsp_vld_q <= rsp_vld_d;
      sts_q     <= sts_d;
      do_q      <= do_d;
    end
  end

  assign Cmd_Rdy  = (state_q == IDLE);
  assign Busy     = !Cmd_Rdy;
  assign SSP_SSEL = ssel_q;
  assign SSP_MOSI = tx_q[FRAME_W-1];
  assign Rsp_Vld  = rsp_vld_q;
  assign Rsp_Sts  = sts_q;
  assign Rsp_DO   = do_q;

endmodule

// File: tb/tb_ssp_master.sv
// Directed bench: default-timing instance (a) and CLK_DIV=1/FRAME_GAP=0 instance (b),
// each with a mode-0 slave model; expected values are hand-computed.
module tb_ssp_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [2:0]  ra;
  logic        wnr;
  logic [11:0] di;
  logic        sel;
  logic [15:0] slave_word;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_vld, a_rdy, a_rsp, a_busy, a_ssel, a_sck, a_mosi, a_miso;
  logic [3:0]  a_sts;
  logic [11:0] a_do;
  logic        b_vld, b_rdy, b_rsp, b_busy, b_ssel, b_sck, b_mosi, b_miso;
  logic [3:0]  b_sts;
  logic [11:0] b_do;

  assign a_vld = vld & ~sel;
  assign b_vld = vld & sel;

  ssp_master u_dut_a (
    .Clk(clk), .Rst(rst_n), .Cmd_Vld(a_vld), .Cmd_Rdy(a_rdy), .Cmd_RA(ra),
    .Cmd_WnR(wnr), .Cmd_DI(di), .Rsp_Vld(a_rsp), .Rsp_Sts(a_sts), .Rsp_DO(a_do),
    .Busy(a_busy), .SSP_SSEL(a_ssel), .SSP_SCK(a_sck), .SSP_MOSI(a_mosi), .SSP_MISO(a_miso)
  );

  ssp_master #(.CLK_DIV(1), .FRAME_GAP(0)) u_dut_b (
    .Clk(clk), .Rst(rst_n), .Cmd_Vld(b_vld), .Cmd_Rdy(b_rdy), .Cmd_RA(ra),
    .Cmd_WnR(wnr), .Cmd_DI(di), .Rsp_Vld(b_rsp), .Rsp_Sts(b_sts), .Rsp_DO(b_do),
    .Busy(b_busy), .SSP_SSEL(b_ssel), .SSP_SCK(b_sck), .SSP_MOSI(b_mosi), .SSP_MISO(b_miso)
  );

  // Slave models: load on select, shift on SCK fall, MSB first.
  logic [15:0] a_sl = 16'h0000, b_sl = 16'h0000, a_cap = 16'h0000, b_cap = 16'h0000;
  logic        a_idle = 1'b1, b_idle = 1'b1;

  always @(negedge a_sck or posedge a_ssel or negedge a_ssel) begin
    if (!a_ssel) a_idle <= 1'b1;
    else if (a_idle) begin a_sl <= slave_word; a_idle <= 1'b0; end
    else a_sl <= {a_sl[14:0], 1'b0};
  end

  always @(negedge b_sck or posedge b_ssel or negedge b_ssel) begin
    if (!b_ssel) b_idle <= 1'b1;
    else if (b_idle) begin b_sl <= slave_word; b_idle <= 1'b0; end
    else b_sl <= {b_sl[14:0], 1'b0};
  end

  assign a_miso = a_sl[15];
  assign b_miso = b_sl[15];

  // MOSI capture on SCK rise; the last 16 bits are the frame.
  always @(posedge a_sck) a_cap <= {a_cap[14:0], a_mosi};
  always @(posedge b_sck) b_cap <= {b_cap[14:0], b_mosi};

  logic        m_rdy, m_rsp, m_busy, m_ssel, m_sck, m_mosi;
  logic [3:0]  m_sts;
  logic [11:0] m_do;
  logic [15:0] m_cap;

  assign m_rdy  = sel ? b_rdy  : a_rdy;
  assign m_rsp  = sel ? b_rsp  : a_rsp;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_ssel = sel ? b_ssel : a_ssel;
  assign m_sck  = sel ? b_sck  : a_sck;
  assign m_mosi = sel ? b_mosi : a_mosi;
  assign m_sts  = sel ? b_sts  : a_sts;
  assign m_do   = sel ? b_do   : a_do;
  assign m_cap  = sel ? b_cap  : a_cap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  int          a0, first_rise, rsp_rel, rdy_rel, rsp_cnt, gap_busy;
  logic [3:0]  rsp_sts;
  logic [11:0] rsp_do;
  logic        ssel_at_rsp, ssel1, mosi1;

  // Follow one frame from the accept cycle (current negedge) until Cmd_Rdy returns.
  task automatic watch(input int budget, input bit hold, input bit scramble);
    logic sck_prev;
    int   rel;
    first_rise = -1; rsp_rel = -1; rdy_rel = -1; rsp_cnt = 0; gap_busy = 0;
    sck_prev = 1'b0; ssel1 = 1'b0; mosi1 = 1'b0; ssel_at_rsp = 1'b1;
    a0 = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      rel = cyc - a0;
      if (!hold) vld = 1'b0;
      if (rel == 1) begin ssel1 = m_ssel; mosi1 = m_mosi; end
      if (m_sck && !sck_prev && first_rise < 0) first_rise = rel;
      sck_prev = m_sck;
      if (m_rsp) begin
        rsp_cnt++; rsp_rel = rel; rsp_sts = m_sts; rsp_do = m_do; ssel_at_rsp = m_ssel;
      end
      if (m_busy && !m_ssel && rsp_rel >= 0) gap_busy++;
      if (m_rdy) begin rdy_rel = rel; break; end
      if (scramble) begin
        ra = 3'($urandom); wnr = 1'($urandom); di = 12'($urandom); vld = 1'($urandom);
      end
    end
    check_eq("rdy_within_budget", 32'(m_rdy), 32'd1);
    if (!hold) vld = 1'b0;
  endtask

  task automatic frame_checks(input string tag, input logic [15:0] mosi_exp,
                              input logic [3:0] sts_exp, input logic [11:0] do_exp,
                              input int rsp_exp);
    check_eq({tag, "_mosi"},    32'(m_cap),   32'(mosi_exp));
    check_eq({tag, "_sts"},     32'(rsp_sts), 32'(sts_exp));
    check_eq({tag, "_do"},      32'(rsp_do),  32'(do_exp));
    check_eq({tag, "_rsp_cyc"}, rsp_rel,      rsp_exp);
    check_eq({tag, "_rsp_cnt"}, rsp_cnt,      1);
    check_eq({tag, "_ssel1"},   32'(ssel1),   32'(1));
    check_eq({tag, "_mosi1"},   32'(mosi1),   32'(mosi_exp[15]));
    check_eq({tag, "_ssel_at_rsp"}, 32'(ssel_at_rsp), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ssel_hi, extra_rsp;
    rst_n = 1'b0; vld = 1'b0; ra = 3'd0; wnr = 1'b0; di = 12'd0; sel = 1'b0;
    slave_word = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_rdy",  32'(a_rdy),  32'd1);
    check_eq("rst_busy", 32'(a_busy), 32'd0);
    check_eq("rst_rsp",  32'(a_rsp),  32'd0);
    check_eq("rst_sts",  32'(a_sts),  32'd0);
    check_eq("rst_do",   32'(a_do),   32'd0);
    check_eq("rst_ssel", 32'(a_ssel), 32'd0);
    check_eq("rst_sck",  32'(a_sck),  32'd0);
    check_eq("rst_mosi", 32'(a_mosi), 32'd0);
    check_eq("rst_b_rdy", 32'(b_rdy), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", 32'(a_rdy), 32'd1);

    // Default write: frame 16'hBA5C, slave 16'h9123
    slave_word = 16'h9123; ra = 3'b101; wnr = 1'b1; di = 12'hA5C; vld = 1'b1;
    watch(300, 1'b0, 1'b0);
    frame_checks("wr", 16'hBA5C, 4'h9, 12'h123, 133);
    check_eq("wr_first_rise", first_rise, 5);
    check_eq("wr_rdy_cyc",    rdy_rel,    135);
    check_eq("wr_sts_hold",   32'(a_sts), 32'h9);

    // Read with Cmd_Vld held: back-to-back accept
    slave_word = 16'hFFFF; ra = 3'b000; wnr = 1'b0; di = 12'h000; vld = 1'b1;
    watch(300, 1'b1, 1'b0);
    frame_checks("rd", 16'h0000, 4'hF, 12'hFFF, 133);
    check_eq("rd_rdy_cyc",  rdy_rel,  135);
    check_eq("rd_gap_busy", gap_busy, 2);
    slave_word = 16'h8001;
    watch(300, 1'b0, 1'b0);
    frame_checks("b2b", 16'h0000, 4'h8, 12'h001, 133);
    check_eq("b2b_rdy_cyc", rdy_rel, 135);

    // Inputs scrambled and Cmd_Vld pulsed while busy
    slave_word = 16'h2C3D; ra = 3'b001; wnr = 1'b1; di = 12'h7E1; vld = 1'b1;
    watch(300, 1'b0, 1'b1);
    frame_checks("scr", 16'h37E1, 4'h2, 12'hC3D, 133);
    ssel_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ssel) ssel_hi++;
    end
    check_eq("scr_no_extra_frame", ssel_hi, 0);

    // Reset in the middle of a frame
    slave_word = 16'hDEAD; ra = 3'b111; wnr = 1'b1; di = 12'hFFF; vld = 1'b1;
    a0 = cyc;
    for (int i = 0; i < 60 && (cyc - a0) < 40; i++) begin
      @(negedge clk);
      vld = 1'b0;
    end
    check_eq("abort_cycle",  cyc - a0,    40);
    check_eq("abort_sck_pre", 32'(a_sck), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ssel", 32'(a_ssel), 32'd0);
    check_eq("abort_sck",  32'(a_sck),  32'd0);
    check_eq("abort_rdy",  32'(a_rdy),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    extra_rsp = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (a_rsp) extra_rsp++;
    end
    check_eq("abort_no_rsp", extra_rsp,  0);
    check_eq("abort_sts",    32'(a_sts), 32'h0);
    check_eq("abort_do",     32'(a_do),  32'h0);
    slave_word = 16'h5A5A; ra = 3'b110; wnr = 1'b0; di = 12'h0F0; vld = 1'b1;
    watch(300, 1'b0, 1'b0);
    frame_checks("post_abort", 16'hC0F0, 4'h5, 12'hA5A, 133);

    // Fast instance: CLK_DIV=1, FRAME_GAP=0
    sel = 1'b1;
    @(negedge clk);
    slave_word = 16'h6A0F; ra = 3'b010; wnr = 1'b1; di = 12'h3C5; vld = 1'b1;
    watch(100, 1'b0, 1'b0);
    frame_checks("fast", 16'h53C5, 4'h6, 12'hA0F, 34);
    check_eq("fast_first_rise", first_rise, 2);
    check_eq("fast_rdy_cyc",    rdy_rel,    34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
